shift_seq_ctrl: RTL and testbench

- Sequencer for the team's 4-bit universal shift register datapath.
- Accepts one command per transaction: parallel-load a word, shift it N places left or right with a fill bit, then capture the result.
- Drives the register's load, shift-enable, direction and serial-in lines, and returns the captured word with a done pulse.
- Sits between a requester (test FSM, UI) and the shift register instance.

---
 rtl/shift_seq_pkg.sv | 16 +
 rtl/shift_seq_cnt.sv | 39 +++
 rtl/shift_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_shift_seq_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared FSM encoding and direction constants for the shift register sequencer.
// Optional rotate support in shift_seq_ctrl is selected by SHIFT_SEQ_ROTATE_EN.
package shift_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/shift_seq_cnt.sv
// Shift-amount down-counter: clamps to WIDTH on load, flags the last shift cycle.
// Latency: count and last are registered; load takes priority over dec.
module shift_seq_cnt
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] shamt_i,
  output logic [CNT_W-1:0] count_o,
  output logic             last_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = (shamt_i > MAX_CNT) ? MAX_CNT : shamt_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;
  assign last_o  = (count_q == CNT_W'(1));

endmodule

// File: rtl/shift_seq_ctrl.sv
// Load/shift/capture sequencer for a universal shift register; done in cycle shamt_eff+3.
// Optional SHIFT_SEQ_ROTATE_EN adds cmd_rot: the exiting bit is recirculated instead of fill.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_shamt,
  input  logic             cmd_fill,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic             cmd_rot,
`endif
  input  logic [WIDTH-1:0] q_in,
  output logic             ready,
  output logic             ld,
  output logic             shift_en,
  output logic             dir,
  output logic [WIDTH-1:0] d,
  output logic             ser_bit,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  state_t           state_q;
  logic             ready_q, ld_q, shift_en_q, done_q;
  logic             dir_q, fill_q;
  logic [WIDTH-1:0] d_q, result_q;
  logic [CNT_W-1:0] count;
  logic             last;
  logic             accept;

  assign accept = (state_q == IDLE) && start;

  shift_seq_cnt #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .load_i  (accept),
    .dec_i   (state_q == SHIFT),
    .shamt_i (cmd_shamt),
    .count_o (count),
    .last_o  (last)
  );

`ifdef SHIFT_SEQ_ROTATE_EN
  logic rot_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       rot_q <= 1'b0;
    else if (accept) rot_q <= cmd_rot;
  end

  // Rotation recirculates the bit leaving the register on this shift.
  assign ser_bit = (rot_q && (state_q == SHIFT))
                 ? ((dir_q == DIR_LEFT) ? q_in[WIDTH-1] : q_in[0])
                 : fill_q;
`else
  assign ser_bit = fill_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      ld_q       <= 1'b0;
      shift_en_q <= 1'b0;
      done_q     <= 1'b0;
      dir_q      <= 1'b0;
      fill_q     <= 1'b0;
      d_q        <= '0;
      result_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            dir_q   <= cmd_dir;
            d_q     <= cmd_data;
            fill_q  <= cmd_fill;
            ready_q <= 1'b0;
            ld_q    <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          ld_q <= 1'b0;
          if (count != '0) begin
            shift_en_q <= 1'b1;
            state_q    <= SHIFT;
          end else begin
            state_q <= CAPTURE;
          end
        end
        SHIFT: begin
          // The counter still reads 1 during the final shift cycle.
          if (last) begin
            shift_en_q <= 1'b0;
            state_q    <= CAPTURE;
          end
        end
        CAPTURE: begin
          result_q <= q_in;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q    <= 1'b1;
          ld_q       <= 1'b0;
          shift_en_q <= 1'b0;
          done_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign ready    = ready_q;
  assign ld       = ld_q;
  assign shift_en = shift_en_q;
  assign done     = done_q;
  assign dir      = dir_q;
  assign d        = d_q;
  assign result   = result_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: reference shift register, cycle-level command model, directed and random commands.
module tb_shift_seq_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             cmd_dir = 1'b0;
  logic [CNT_W-1:0] cmd_shamt = '0;
  logic             cmd_fill = 1'b0;
  logic             cmd_rot = 1'b0;
  logic [WIDTH-1:0] q_reg = '0;
  logic             ready, ld, shift_en, dir, ser_bit, done;
  logic [WIDTH-1:0] d, result;

  int n_tests = 0;
  int n_fail  = 0;

  shift_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cmd_data  (cmd_data),
    .cmd_dir   (cmd_dir),
    .cmd_shamt (cmd_shamt),
    .cmd_fill  (cmd_fill),
`ifdef SHIFT_SEQ_ROTATE_EN
    .cmd_rot   (cmd_rot),
`endif
    .q_in      (q_reg),
    .ready     (ready),
    .ld        (ld),
    .shift_en  (shift_en),
    .dir       (dir),
    .d         (d),
    .ser_bit   (ser_bit),
    .result    (result),
    .done      (done)
  );

  always #5 clk = ~clk;

  // The 4-bit universal shift register the sequencer drives.
  always @(posedge clk) begin
    if (ld)            q_reg <= d;
    else if (shift_en) q_reg <= dir ? {q_reg[WIDTH-2:0], ser_bit} : {ser_bit, q_reg[WIDTH-1:1]};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] shift_model(input logic [WIDTH-1:0] data, input logic dr,
                                                   input int n, input logic fill, input logic rot);
    logic [WIDTH-1:0] q;
    q = data;
    for (int i = 0; i < n; i++) begin
      if (dr) q = {q[WIDTH-2:0], rot ? q[WIDTH-1] : fill};
      else    q = {rot ? q[0] : fill, q[WIDTH-1:1]};
    end
    return q;
  endfunction

  // Command-level model: m_k counts cycles since acceptance (1 = load cycle).
  logic             m_act = 1'b0, m_dir = 1'b0, m_fill = 1'b0, m_rot = 1'b0;
  logic [WIDTH-1:0] m_d = '0, m_res = '0, m_next = '0;
  int               m_k = 0, m_eff = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act = 1'b0; m_k = 0; m_dir = 1'b0; m_d = '0; m_fill = 1'b0; m_rot = 1'b0; m_res = '0;
    end else if (m_act) begin
      m_k++;
      if (m_k == m_eff + 3) m_res = m_next;
      else if (m_k > m_eff + 3) begin m_act = 1'b0; m_k = 0; end
    end else if (start) begin
      m_act  = 1'b1;
      m_k    = 1;
      m_dir  = cmd_dir;
      m_d    = cmd_data;
      m_fill = cmd_fill;
`ifdef SHIFT_SEQ_ROTATE_EN
      m_rot  = cmd_rot;
`endif
      m_eff  = (int'(cmd_shamt) > WIDTH) ? WIDTH : int'(cmd_shamt);
      m_next = shift_model(cmd_data, cmd_dir, m_eff, cmd_fill, m_rot);
    end
  end

  always @(negedge clk) begin : compare
    logic e_sh, e_ser;
    e_sh  = m_act && (m_k >= 2) && (m_k <= m_eff + 1);
    e_ser = (m_rot && e_sh) ? (m_dir ? q_reg[WIDTH-1] : q_reg[0]) : m_fill;
    chk("ready",    ready,    !m_act);
    chk("ld",       ld,       m_act && (m_k == 1));
    chk("shift_en", shift_en, e_sh);
    chk("done",     done,     m_act && (m_k == m_eff + 3));
    chk("dir",      dir,      m_dir);
    chk("d",        d,        m_d);
    chk("ser_bit",  ser_bit,  e_ser);
    chk("result",   result,   m_res);
  end

  task automatic run_cmd(input logic [WIDTH-1:0] data, input logic dr, input logic [CNT_W-1:0] sh,
                         input logic fill, input logic rot,
                         output int done_cyc, output logic [WIDTH-1:0] res, output int n_ld, output int n_sh);
    done_cyc = -1; res = '0; n_ld = 0; n_sh = 0;
    @(posedge clk); #1;
    start = 1'b1; cmd_data = data; cmd_dir = dr; cmd_shamt = sh; cmd_fill = fill; cmd_rot = rot;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ld) n_ld++;
      if (shift_en) n_sh++;
      if (done) begin done_cyc = n; res = result; break; end
    end
  endtask

  int               dc, nl, ns;
  logic [WIDTH-1:0] rs;

  initial begin
    #1 reset = 1'b1;
    #2;
    chk("rst_ready", ready, 1'b1);
    chk("rst_ld", ld, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 4'b0000);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_cmd(4'b1011, 1'b1, 3'd2, 1'b0, 1'b0, dc, rs, nl, ns);
    chk("t1_done_cyc", dc, 5);
    chk("t1_result", rs, 4'b1100);
    chk("t1_shifts", ns, 2);
    chk("t1_loads", nl, 1);

    run_cmd(4'b1011, 1'b0, 3'd1, 1'b1, 1'b0, dc, rs, nl, ns);
    chk("t2_done_cyc", dc, 4);
    chk("t2_result", rs, 4'b1101);

    run_cmd(4'b1011, 1'b1, 3'd0, 1'b0, 1'b0, dc, rs, nl, ns);
    chk("t3_done_cyc", dc, 3);
    chk("t3_shifts", ns, 0);
    chk("t3_result", rs, 4'b1011);

    run_cmd(4'b0100, 1'b0, 3'd7, 1'b1, 1'b0, dc, rs, nl, ns);
    chk("t4_shifts", ns, 4);
    chk("t4_done_cyc", dc, 7);
    chk("t4_result", rs, 4'b1111);

    // Second start during SHIFT is ignored, then reset lands mid-SHIFT.
    @(posedge clk); #1;
    start = 1'b1; cmd_data = 4'b1011; cmd_dir = 1'b1; cmd_shamt = 3'd4; cmd_fill = 1'b0; cmd_rot = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 start = 1'b1; cmd_data = 4'b0000;
    nl = 0;
    @(negedge clk); if (ld) nl++;
    @(negedge clk); if (ld) nl++;
    chk("t5_no_reload", nl, 0);
    chk("t5_shifting", shift_en, 1'b1);
    chk("t5_d_kept", d, 4'b1011);
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b1;
    #1;
    chk("t5_rst_ready", ready, 1'b1);
    chk("t5_rst_shift_en", shift_en, 1'b0);
    chk("t5_rst_ld", ld, 1'b0);
    chk("t5_rst_d", d, 4'b0000);
    chk("t5_rst_result", result, 4'b0000);
    @(posedge clk); #1 reset = 1'b0;
    run_cmd(4'b0110, 1'b0, 3'd2, 1'b1, 1'b0, dc, rs, nl, ns);
    chk("t5_fresh_done_cyc", dc, 5);
    chk("t5_fresh_result", rs, 4'b1101);

`ifdef SHIFT_SEQ_ROTATE_EN
    run_cmd(4'b1011, 1'b1, 3'd1, 1'b0, 1'b1, dc, rs, nl, ns);
    chk("rot_left", rs, 4'b0111);
    run_cmd(4'b1011, 1'b0, 3'd1, 1'b0, 1'b1, dc, rs, nl, ns);
    chk("rot_right", rs, 4'b1101);
`endif

    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 79) == 0) reset = 1'b1;
      start     = 1'($urandom_range(0, 1));
      cmd_data  = WIDTH'($urandom);
      cmd_dir   = 1'($urandom_range(0, 1));
      cmd_shamt = CNT_W'($urandom);
      cmd_fill  = 1'($urandom_range(0, 1));
`ifdef SHIFT_SEQ_ROTATE_EN
      cmd_rot   = 1'($urandom_range(0, 1));
`endif
    end
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
